ps2_key_event_decoder: RTL

Parametrised successor to the keyboard_read/keyboard_display pair. Consumes raw bytes from ps2_keyboard and parses PS/2 set-2 sequences (plain, E0-extended, F0-break). Tracks held-key and left/right modifier state and suppresses typematic repeats. Pushes decoded key events into a DEPTH-entry show-ahead FIFO with a valid/ready pop interface, feeding display or CPU-side logic.

---
 rtl/ps2_key_event_decoder.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
//   Purpose : pops raw PS/2 set-2 bytes from ps2_keyboard, parses E0/F0 prefixes,
//             tracks held key and left/right modifiers, filters typematic repeats,
//             and queues decoded key events in a show-ahead FIFO.
//   Ports   : clk/rst (async active-high); ps2_data/ps2_ready/ps2_nextdata_n byte
//             pop handshake; evt_* valid/ready event head; *_flag live modifiers;
//             key_count accepted makes; fifo_level occupancy; overflow/ovf_clr sticky drop.
//   Latency : byte accepted in T, parsed in T+1, event visible at FIFO head in T+2.
module ps2_key_event_decoder #(
   parameter int DEPTH         = 8,
   parameter int CNT_W         = 8,
   parameter bit FILTER_REPEAT = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 ps2_data,
   input  logic                       ps2_ready,
   output logic                       ps2_nextdata_n,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [7:0]                 evt_code,
   output logic                       evt_ext,
   output logic                       evt_break,
   output logic                       evt_shift,
   output logic                       evt_ctrl,
   output logic                       evt_alt,
   output logic                       shift_flag,
   output logic                       ctrl_flag,
   output logic                       alt_flag,
   output logic [CNT_W-1:0]           key_count,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       shift;
      logic       ctrl;
      logic       alt;
   } evt_t;

   // Modifier bit positions inside mod_q
   localparam int M_LSHIFT = 0;
   localparam int M_RSHIFT = 1;
   localparam int M_LCTRL  = 2;
   localparam int M_RCTRL  = 3;
   localparam int M_LALT   = 4;
   localparam int M_RALT   = 5;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic              pop_q,      pop_d;
   logic [7:0]        byte_q,     byte_d;
   state_t            state_q,    state_d;
   logic              held_vld_q, held_vld_d;
   logic [8:0]        held_q,     held_d;
   logic [5:0]        mod_q,      mod_d;
   logic [CNT_W-1:0]  count_q,    count_d;
   logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
   logic [AW:0]       level_q,    level_d;
   evt_t              last_q,     last_d;
   logic              ovf_q,      ovf_d;

   evt_t              mem_q [DEPTH];

   // ------------------------------------------------------------------
   // Byte capture: pop_q doubles as the "byte_q is fresh" marker and as the
   // pop strobe, so a new byte can never be taken while the strobe is low.
   // ------------------------------------------------------------------
   logic cap;

   always_comb begin
      cap    = ps2_ready && !pop_q;
      pop_d  = cap;
      byte_d = cap ? ps2_data : byte_q;
   end

   // ------------------------------------------------------------------
   // Parser
   // ------------------------------------------------------------------
   logic emit, emit_ext, emit_brk;

   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      emit_ext = 1'b0;
      emit_brk = 1'b0;
      if (pop_q) begin
         unique case (state_q)
            ST_IDLE: begin
               if (byte_q == 8'hE0)      state_d = ST_EXT;
               else if (byte_q == 8'hF0) state_d = ST_BRK;
               else                      emit    = 1'b1;
            end
            ST_EXT: begin
               if (byte_q == 8'hF0)      state_d = ST_EXT_BRK;
               else if (byte_q == 8'hE0) state_d = ST_EXT;
               else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_BRK: begin
               // E0 after F0 means we lost sync; restart as an extended code
               if (byte_q == 8'hF0)      state_d = ST_BRK;
               else if (byte_q == 8'hE0) state_d = ST_EXT;
               else begin
                  emit     = 1'b1;
                  emit_brk = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if (byte_q == 8'hF0)      state_d = ST_EXT_BRK;
               else if (byte_q == 8'hE0) state_d = ST_EXT;
               else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  emit_brk = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Repeat filter, modifiers, key counter
   // ------------------------------------------------------------------
   logic [8:0] key;
   logic       held_hit;
   logic       suppress;
   logic       accept;
   logic [5:0] mod_mask;

   always_comb begin
      key      = {emit_ext, byte_q};
      held_hit = held_vld_q && (held_q == key);
      suppress = emit && !emit_brk && FILTER_REPEAT && held_hit;
      accept   = emit && !suppress;

      mod_mask = '0;
      unique case (key)
         9'h012:  mod_mask[M_LSHIFT] = 1'b1;
         9'h059:  mod_mask[M_RSHIFT] = 1'b1;
         9'h014:  mod_mask[M_LCTRL]  = 1'b1;
         9'h114:  mod_mask[M_RCTRL]  = 1'b1;
         9'h011:  mod_mask[M_LALT]   = 1'b1;
         9'h111:  mod_mask[M_RALT]   = 1'b1;
         default: mod_mask           = '0;
      endcase

      held_d     = held_q;
      held_vld_d = held_vld_q;
      mod_d      = mod_q;
      count_d    = count_q;
      if (accept) begin
         if (emit_brk) begin
            if (held_hit) held_vld_d = 1'b0;
            mod_d = mod_q & ~mod_mask;
         end else begin
            held_d     = key;
            held_vld_d = 1'b1;
            mod_d      = mod_q | mod_mask;
            count_d    = count_q + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------
   evt_t new_evt;
   evt_t head;
   logic full, fifo_pop, push_ok, drop;

   always_comb begin
      new_evt.code  = byte_q;
      new_evt.ext   = emit_ext;
      new_evt.brk   = emit_brk;
      // snapshot is taken from the flops, i.e. before this event applies
      new_evt.shift = mod_q[M_LSHIFT] | mod_q[M_RSHIFT];
      new_evt.ctrl  = mod_q[M_LCTRL]  | mod_q[M_RCTRL];
      new_evt.alt   = mod_q[M_LALT]   | mod_q[M_RALT];

      full     = (level_q == (AW+1)'(DEPTH));
      fifo_pop = (level_q != '0) && evt_ready;
      // a pop in the same cycle frees a slot, so a full FIFO can still accept
      push_ok  = accept && (!full || fifo_pop);
      drop     = accept && full && !fifo_pop;

      wr_ptr_d = push_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = fifo_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, fifo_pop};

      // when the FIFO drains, outputs keep showing the last popped entry
      last_d   = fifo_pop ? mem_q[rd_ptr_q] : last_q;
      head     = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;

      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
      else              ovf_d = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= new_evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_q      <= 1'b0;
         byte_q     <= '0;
         state_q    <= ST_IDLE;
         held_vld_q <= 1'b0;
         held_q     <= '0;
         mod_q      <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         last_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         pop_q      <= pop_d;
         byte_q     <= byte_d;
         state_q    <= state_d;
         held_vld_q <= held_vld_d;
         held_q     <= held_d;
         mod_q      <= mod_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      ps2_nextdata_n = ~pop_q;
      evt_valid      = (level_q != '0);
      evt_code       = head.code;
      evt_ext        = head.ext;
      evt_break      = head.brk;
      evt_shift      = head.shift;
      evt_ctrl       = head.ctrl;
      evt_alt        = head.alt;
      shift_flag     = mod_q[M_LSHIFT] | mod_q[M_RSHIFT];
      ctrl_flag      = mod_q[M_LCTRL]  | mod_q[M_RCTRL];
      alt_flag       = mod_q[M_LALT]   | mod_q[M_RALT];
      key_count      = count_q;
      fifo_level     = level_q;
      overflow       = ovf_q;
   end

endmodule
